// File: rtl/dc_pkg.sv
// Shared definitions for the reconfiguration-control register block:
// register offsets, field bit positions, FSM state encoding and the status word packer.
package dc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RECONF = 2'd2
    } state_t;

    localparam logic [2:0] OFF_TRIG   = 3'd0;
    localparam logic [2:0] OFF_CTRL   = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_INFO   = 3'd3;

    localparam int TRIG_BIT    = 0;
    localparam int OVR_BIT     = 0;
    localparam int SEL_BIT     = 1;
    localparam int ERR_CLR_BIT = 1;

    function automatic logic [31:0] info_word(input logic [7:0] trig_cnt, input logic err,
                                              input logic pend, input logic image);
        return {16'h0000, trig_cnt, 5'b00000, err, pend, image};
    endfunction

endpackage

// File: rtl/dc_avmm_rsp.sv
// Avalon-MM slave that controls a dual-image reconfiguration request: a config
// write holds off new commands for BUSY_CYCLES, a trigger pulses o_reconf and then swaps the image.
module dc_avmm_rsp
    import dc_pkg::*;
#(
    parameter int BUSY_CYCLES   = 16,
    parameter int RECONF_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_avmm_address,
    input  logic        i_avmm_read,
    input  logic        i_avmm_write,
    input  logic [31:0] i_avmm_writedata,
    output logic [31:0] o_avmm_readdata,
    input  logic        i_conf_sel_pin,
    output logic        o_reconf,
    output logic        o_image,
    output logic        o_busy
);

    localparam logic [7:0] BUSY_LOAD   = 8'(BUSY_CYCLES);
    localparam logic [7:0] RECONF_LOAD = 8'(RECONF_CYCLES);

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        ovr_r, sel_r, err_r, pend_r, image_r, reconf_r, busy_r;
    logic [7:0]  trig_cnt_r;
    logic [31:0] rdata_r, rd_mux_s;
    logic        wr_trig_s, wr_ctrl_s, clr_err_s;
    logic        start_busy_s, start_reconf_s, finish_reconf_s, reject_s;
    logic        unused_wd_s;

    assign wr_trig_s   = i_avmm_write && (i_avmm_address == OFF_TRIG) && i_avmm_writedata[TRIG_BIT];
    assign wr_ctrl_s   = i_avmm_write && (i_avmm_address == OFF_CTRL);
    assign clr_err_s   = i_avmm_write && (i_avmm_address == OFF_INFO) && i_avmm_writedata[ERR_CLR_BIT];
    assign unused_wd_s = ^i_avmm_writedata[31:2];

    // FSM state and countdown register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; the countdown exits on the cycle it would reach zero
    always_comb begin
        state_s         = state_r;
        cnt_s           = cnt_r;
        start_busy_s    = 1'b0;
        start_reconf_s  = 1'b0;
        finish_reconf_s = 1'b0;
        reject_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wr_ctrl_s) begin
                    state_s      = ST_BUSY;
                    cnt_s        = BUSY_LOAD;
                    start_busy_s = 1'b1;
                end else if (wr_trig_s) begin
                    state_s        = ST_RECONF;
                    cnt_s          = RECONF_LOAD;
                    start_reconf_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY, ST_RECONF: begin
                reject_s = wr_ctrl_s || wr_trig_s;
                if (cnt_r <= 8'd1) begin
                    state_s         = ST_IDLE;
                    cnt_s           = 8'd0;
                    finish_reconf_s = (state_r == ST_RECONF);
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // Read mux over the pre-write register contents
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (i_avmm_address)
            OFF_TRIG:   rd_mux_s = 32'h0000_0000;
            OFF_CTRL:   rd_mux_s = {30'h0000_0000, sel_r, ovr_r};
            OFF_STATUS: rd_mux_s = {31'h0000_0000, busy_r};
            OFF_INFO:   rd_mux_s = info_word(trig_cnt_r, err_r, pend_r, image_r);
            default:    rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Register file, image/trigger bookkeeping and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovr_r      <= 1'b0;
            sel_r      <= 1'b0;
            err_r      <= 1'b0;
            pend_r     <= 1'b0;
            image_r    <= 1'b0;
            trig_cnt_r <= 8'd0;
            busy_r     <= 1'b0;
            reconf_r   <= 1'b0;
            rdata_r    <= 32'h0000_0000;
        end else begin
            busy_r   <= (state_s != ST_IDLE);
            reconf_r <= (state_s == ST_RECONF);
            if (start_busy_s) begin
                ovr_r <= i_avmm_writedata[OVR_BIT];
                sel_r <= i_avmm_writedata[SEL_BIT];
            end else if (finish_reconf_s) begin
                ovr_r <= 1'b0;
            end
            if (start_reconf_s) begin
                pend_r <= ovr_r ? sel_r : i_conf_sel_pin;
            end
            if (finish_reconf_s) begin
                image_r    <= pend_r;
                trig_cnt_r <= trig_cnt_r + 8'd1;
            end
            if (reject_s) begin
                err_r <= 1'b1;
            end else if (clr_err_s) begin
                err_r <= 1'b0;
            end
            if (i_avmm_read) begin
                rdata_r <= rd_mux_s;
            end
        end
    end

    assign o_avmm_readdata = rdata_r;
    assign o_reconf        = reconf_r;
    assign o_image         = image_r;
    assign o_busy          = busy_r;

endmodule

// File: tb/tb_dc_avmm_rsp.sv
// Self-checking bench for dc_avmm_rsp: constant vector table, directed corner
// sequences and randomized traffic against a timestamp-based reference model.
module tb_dc_avmm_rsp;

    localparam int BUSY_N   = 16;
    localparam int RECONF_N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  addr = 3'd0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wd = 32'h0;
    logic [31:0] rdata;
    logic        pin = 1'b0;
    logic        reconf, image, busy;

    int n_pass = 0;
    int n_total = 0;

    dc_avmm_rsp #(.BUSY_CYCLES(BUSY_N), .RECONF_CYCLES(RECONF_N)) dut (
        .i_clk(clk), .i_rst(rst), .i_avmm_address(addr), .i_avmm_read(rd),
        .i_avmm_write(wr), .i_avmm_writedata(wd), .o_avmm_readdata(rdata),
        .i_conf_sel_pin(pin), .o_reconf(reconf), .o_image(image), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: the controller is unavailable until edge index free_at
    longint ecount = 0;
    longint free_at = 0;
    bit     m_reconf_op = 1'b0;
    bit     m_ovr, m_sel, m_err, m_pend, m_img;
    int     m_trig;
    logic [31:0] m_rd;

    function automatic logic [31:0] m_reg(input logic [2:0] a);
        logic [7:0] t;
        t = 8'(m_trig);
        case (a)
            3'd1:    return {30'h0, m_sel, m_ovr};
            3'd2:    return {31'h0, (ecount < free_at)};
            3'd3:    return {16'h0, t, 5'h0, m_err, m_pend, m_img};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        free_at = 0; m_reconf_op = 1'b0;
        m_ovr = 1'b0; m_sel = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_img = 1'b0;
        m_trig = 0; m_rd = 32'h0;
    endtask

    task automatic model_step(input logic r, input logic w, input logic [2:0] a,
                              input logic [31:0] d, input logic p);
        bit idle;
        idle = (ecount >= free_at);
        if (r) m_rd = m_reg(a);
        if (!idle && m_reconf_op && ecount == free_at - 1) begin
            m_img = m_pend; m_trig = (m_trig + 1) % 256; m_ovr = 1'b0;
        end
        if (w) begin
            if (a == 3'd0 && d[0]) begin
                if (idle) begin
                    m_pend = m_ovr ? m_sel : p;
                    free_at = ecount + RECONF_N + 1; m_reconf_op = 1'b1;
                end else m_err = 1'b1;
            end else if (a == 3'd1) begin
                if (idle) begin
                    m_ovr = d[0]; m_sel = d[1];
                    free_at = ecount + BUSY_N + 1; m_reconf_op = 1'b0;
                end else m_err = 1'b1;
            end else if (a == 3'd3 && d[1]) begin
                m_err = 1'b0;
            end
        end
        ecount++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_model();
        bit mb;
        mb = (ecount < free_at);
        chk("m_busy", {31'h0, busy}, {31'h0, mb});
        chk("m_reconf", {31'h0, reconf}, {31'h0, mb && m_reconf_op});
        chk("m_image", {31'h0, image}, {31'h0, m_img});
        chk("m_rdata", rdata, m_rd);
    endtask

    // One bus cycle: drive at negedge, model at posedge, sample at next negedge
    task automatic tick(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        rd = r; wr = w; addr = a; wd = d;
        @(posedge clk);
        model_step(r, w, a, d, pin);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        chk_model();
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_reconf", {31'h0, reconf}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_image", {31'h0, image}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int ones, hi;
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0,        32'h0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'd1, 32'h0,        32'h0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'd5, 32'hFFFFFFFF, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'd5, 32'h0,        32'h0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'd0, 32'hFFFFFFFE, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'd3, 32'h0,        32'h0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'd1, 32'h3,        32'h0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 3'd1, 32'h0,        32'h3, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 3'd2, 32'h0,        32'h1, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 3'd0, 32'h1,        32'h1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 3'd3, 32'h0,        32'h4, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 3'd3, 32'h2,        32'h4, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 3'd3, 32'h0,        32'h0, 1'b1};

        model_reset();
        do_reset();

        for (int i = 0; i < 13; i++) begin
            tick(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].exp_busy});
        end
        idle_n(20);

        // Busy window after a config write, then read back
        tick(1'b0, 1'b1, 3'd1, 32'h3);
        ones = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, 3'd2, 32'h0);
            if (i == 0) chk("busy_first", rdata, 32'h1);
            if (rdata == 32'h1) ones++;
        end
        chk("busy_len", 32'(ones), 32'd16);
        chk("busy_end", rdata, 32'h0);
        tick(1'b1, 1'b0, 3'd1, 32'h0);
        chk("ctrl_rb", rdata, 32'h3);

        // Override trigger selects image 1 and clears ovr
        tick(1'b0, 1'b1, 3'd0, 32'h1);
        hi = reconf ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, 1'b0, 3'd0, 32'h0);
            if (reconf) hi++;
        end
        chk("reconf_len", 32'(hi), 32'd4);
        chk("image_ovr", {31'h0, image}, 32'h1);
        tick(1'b1, 1'b0, 3'd3, 32'h0);
        chk("info_ovr", rdata, 32'h103);
        tick(1'b1, 1'b0, 3'd1, 32'h0);
        chk("ctrl_after", rdata, 32'h2);

        // Pin-selected trigger from a fresh reset
        do_reset();
        pin = 1'b0;
        tick(1'b0, 1'b1, 3'd0, 32'h1);
        idle_n(6);
        chk("image_pin", {31'h0, image}, 32'h0);
        tick(1'b1, 1'b0, 3'd3, 32'h0);
        chk("info_pin", rdata, 32'h100);

        // Config write while busy is rejected and flagged
        tick(1'b0, 1'b1, 3'd1, 32'h1);
        tick(1'b0, 1'b1, 3'd1, 32'h2);
        tick(1'b1, 1'b0, 3'd1, 32'h0);
        chk("ctrl_kept", rdata, 32'h1);
        tick(1'b1, 1'b0, 3'd3, 32'h0);
        chk("err_set", rdata, 32'h104);
        tick(1'b0, 1'b1, 3'd3, 32'h2);
        tick(1'b1, 1'b0, 3'd3, 32'h0);
        chk("err_clr", rdata, 32'h100);
        idle_n(20);

        // Reset in the second RECONF cycle aborts the swap
        do_reset();
        pin = 1'b1;
        tick(1'b0, 1'b1, 3'd0, 32'h1);
        tick(1'b0, 1'b0, 3'd0, 32'h0);
        chk("reconf_mid", {31'h0, reconf}, 32'h1);
        do_reset();
        idle_n(6);
        chk("abort_image", {31'h0, image}, 32'h0);
        tick(1'b1, 1'b0, 3'd3, 32'h0);
        chk("abort_info", rdata, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  ra;
            logic [31:0] rdv;
            logic        rr, rw;
            if ($urandom_range(0, 499) == 0) do_reset();
            pin = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            rr  = 1'($urandom_range(0, 1));
            rw  = ($urandom_range(0, 5) == 0);
            rdv = $urandom;
            tick(rr, rw, ra, rdv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
